// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the ADG715 switch target
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [4:0] ADG715_BASE_ADDR = 5'b10010;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - SCL/SDA synchronizers with edge, START and STOP pulses
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_level,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];

  // Idle bus level is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_now;
      sda_prev <= sda_now;
    end
  end

  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  assign sda_level = sda_now;

  // SCL must be high in both samples: an SDA edge coincident with an SCL edge is data.
  assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

endmodule

// File: rtl/i2c_switch_target.sv
// rtl/i2c_switch_target.sv - I2C target modelling the ADG715 octal switch register
module i2c_switch_target
  import i2c_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR   = ADG715_BASE_ADDR,
  parameter logic [7:0] RESET_STATE = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rst_asw_n,
  input  logic [1:0] addr_pins,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] switch_state,
  output logic       wr_strobe,
  output logic       busy
);

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] switch_q, switch_d;
  logic       strobe_q, strobe_d;
  logic       busy_q, busy_d;

  logic       scl_rise;
  logic       scl_fall;
  logic       sda_level;
  logic       start_det;
  logic       stop_det;
  logic [6:0] dev_addr;

  assign dev_addr = {BASE_ADDR, addr_pins};

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (SCL),
    .sda      (SDA),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_level(sda_level),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  // Either reset releases the line combinationally so SDA is freed in the same clk.
  assign SDA = (sda_low_q && reset_n && rst_asw_n) ? 1'b0 : 1'bz;

  assign switch_state = switch_q;
  assign wr_strobe    = strobe_q;
  assign busy         = busy_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'h00;
      sda_low_q <= 1'b0;
      switch_q  <= RESET_STATE;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sda_low_q <= sda_low_d;
      switch_q  <= switch_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sda_low_d = sda_low_q;
    switch_d  = switch_q;
    strobe_d  = 1'b0;
    busy_d    = busy_q;

    if (!rst_asw_n) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      switch_d  = RESET_STATE;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_level};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // On the 8th rise shreg_q[6:0] already holds the seven address bits.
            if (bit_cnt_q == 4'd7 && shreg_q[6:0] != dev_addr) begin
              state_d = IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_low_d = 1'b1;
            state_d   = ADDR_ACK;
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shreg_q[0] == 1'b0) begin
              sda_low_d = 1'b0;
              state_d   = WR_DATA;
            end else begin
              shreg_d   = switch_q;
              sda_low_d = ~switch_q[7];
              state_d   = RD_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_level};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            switch_d  = shreg_q;
            strobe_d  = 1'b1;
            sda_low_d = 1'b1;
            state_d   = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              state_d   = RD_ACK;
            end else begin
              // Open-drain: a 1 bit is presented by releasing the line.
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_low_d = ~shreg_q[6];
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_level == I2C_NACK) begin
              state_d = IGNORE;
            end
          end else if (scl_fall) begin
            shreg_d   = switch_q;
            sda_low_d = ~switch_q[7];
            bit_cnt_d = 4'd0;
            state_d   = RD_DATA;
          end
        end

        IGNORE: begin
          sda_low_d = 1'b0;
        end

        default: begin
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_switch_target.md
Name: i2c_switch_target

Overview:
- Synthesizable I2C target that models the ADG715 octal switch; it is the responder for the switch-controller I2C initiator.
- Decodes START, 7-bit address, R/W, data bytes and STOP on SCL/SDA, and ACKs its address and write bytes. It holds the 8-bit switch register and returns it on reads.
- Used in the board-level loopback bench and as an on-FPGA stand-in when the real switch is unpopulated.

Parameters:
- BASE_ADDR, 5'b10010, fixed upper 5 address bits; full address = {BASE_ADDR, addr_pins}.
- RESET_STATE, 8'h00, switch register value after reset or rst_asw_n low.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA inputs (min 2).

Ports:
- clk  input  1  system clock, 100MHz.
- reset_n  input  1  synchronous active-low reset.
- rst_asw_n  input  1  device RESET pin, active low; clears switch register, target ignores bus while low.
- addr_pins  input  2  A1:A0 strap.
- SCL  input  1  I2C clock from initiator, 400kHz max.
- SDA  inout  1  I2C data; driven only 1'b0 or 1'bz.
- switch_state  output  8  current switch register; bit n = channel n closed.
- wr_strobe  output  1  one-clk pulse on each switch_state update from the bus.
- busy  output  1  high from START until STOP/abort.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (reset_n).
- Reset values: switch_state=RESET_STATE, wr_strobe=0, busy=0, SDA=z, FSM=IDLE.
- Synchronizers: SCL and SDA pass through SYNC_STAGES flops. Edges are detected from the last two synchronized samples.
- START: SDA fall while SCL high. Accepted from any state, including mid-byte, as a repeated start.
  - Clears the bit counter, sets busy=1, goes to ADDR.
- STOP: SDA rise while SCL high. From any state: release SDA, busy=0, go to IDLE.
- Bit sampling: SDA is sampled on the SCL rising edge, MSB first.
- Target drive: the target changes SDA only in the clk after an SCL falling edge.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th rise, compare bits[7:1] with {BASE_ADDR, addr_pins}.
    - Match: on the next SCL fall, drive SDA=0 and go to ADDR_ACK.
    - Mismatch: go to IGNORE, SDA=z.
  - ADDR_ACK: on the 9th SCL fall, release SDA.
    - R/W=0: go to WR_DATA.
    - R/W=1: load the shift register with switch_state, drive its MSB (0 -> drive 0, 1 -> z), go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th SCL fall:
    - switch_state <= received byte; wr_strobe=1 for exactly one clk.
    - Drive SDA=0, go to WR_ACK.
    - Multiple bytes are allowed; the last byte wins.
  - WR_ACK: on the 9th SCL fall, release SDA, go to WR_DATA.
  - RD_DATA: present bits 6..0 on successive SCL falls. On the 8th fall release SDA, go to RD_ACK.
  - RD_ACK: sample the initiator ACK on the 9th rise.
    - ACK (0): reload switch_state, drive MSB on the next fall, go to RD_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA=z; wait for START or STOP.
- rst_asw_n=0:
  - Same clk: switch_state=RESET_STATE, SDA=z, FSM=IDLE, busy=0.
  - No wr_strobe is generated.
  - START is not recognized while rst_asw_n is low.
- reset_n low mid-transaction: SDA released in the same clk; all outputs go to reset values.
- Edge cases:
  - Simultaneous START/STOP detect is impossible (single SDA edge).
  - If SCL and SDA change in the same synchronized sample, SCL wins: treated as a data bit, not START/STOP.
- Latency:
  - switch_state updates SYNC_STAGES+1 clks after the 8th data SCL falling edge at the pin.
  - ACK assertion has the same latency and must meet I2C data hold (≥0 after SCL fall).
- Bit counter: 4 bits, wraps to 0 at each byte boundary after the ACK bit.

Decomposition:
- Package i2c_pkg:
  - FSM state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE).
  - ADG715_BASE_ADDR = 5'b10010.
  - I2C_ACK=1'b0 and I2C_NACK=1'b1 constants.
- Sub-module i2c_bus_monitor: synchronizers plus scl_rise, scl_fall, start_det, stop_det pulses. Reusable by other I2C targets.

Test Plan:
- addr_pins=2'b01; write 0x92, 0x04, STOP. Required: ACK on both bytes, switch_state=0x04, one wr_strobe, busy=0 after STOP.
- Write 0x94 (wrong address), 0xFF. Required: SDA never driven low, switch_state unchanged, no wr_strobe.
- Write 0x92, 0x01, 0x80, STOP. Required: two wr_strobe pulses, switch_state 0x01 then 0x80.
- With switch_state=0x04: START, 0x93, initiator NACK. Required: target ACKs the address, shifts out 0x04, releases SDA, IGNORE until STOP.
- Write 0x92, 3 bits of data, repeated START, 0x92, 0x20. Required: the partial byte is discarded, switch_state=0x20.
- Mid-write, pulse rst_asw_n low for 1 clk, then also repeat with reset_n. Required: switch_state=0x00, SDA=z, the rest of the transaction is ignored until the next START.
